// File: rtl/axis_frame_sanitizer.sv
// axis_frame_sanitizer: forces an AXI4-Stream into WIDTH x HEIGHT frames (tuser=SOF, tlast=EOL).
// Define FRAME_SANITIZER_STATS_EN to add the saturating err_count output.
module axis_frame_sanitizer #(
   parameter int WIDTH = 1920,
   parameter int HEIGHT = 1080,
   parameter int DATA_WIDTH = 24,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  frame_err
`ifdef FRAME_SANITIZER_STATS_EN
   ,
   output logic [15:0]           err_count
`endif
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
   typedef enum logic [2:0] {WAIT_SOF, PASS, PAD_LINE, PAD_FRAME, DRAIN} state_t;
   state_t st;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic run, out_free, accept, padding, emit, early, eol, eof;
   assign out_free = !m_axis_tvalid || m_axis_tready;
   assign padding = st == PAD_LINE || st == PAD_FRAME;
   // a SOF seen mid-frame is held on the input, never consumed here
   assign s_axis_tready = run && out_free &&
                          (st == WAIT_SOF || ((st == PASS || st == DRAIN) && !s_axis_tuser));
   assign accept = s_axis_tready && s_axis_tvalid;
   assign early = run && out_free && s_axis_tvalid && s_axis_tuser && (st == PASS || st == DRAIN);
   assign emit = (accept && (st == PASS || (st == WAIT_SOF && s_axis_tuser))) || (out_free && padding);
   assign eol = x == XW'(WIDTH - 1);
   assign eof = eol && y == YW'(HEIGHT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= WAIT_SOF;
         x <= '0;
         y <= '0;
         run <= 1'b0;
         frame_err <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tlast <= 1'b0;
         m_axis_tuser <= 1'b0;
      end else begin
         run <= 1'b1;
         frame_err <= 1'b0;
         if (out_free) m_axis_tvalid <= emit;
         if (emit) begin
            m_axis_tdata <= padding ? PAD_VALUE : s_axis_tdata;
            m_axis_tlast <= eol;
            m_axis_tuser <= x == '0 && y == '0;
            x <= eol ? '0 : x + 1'b1;
            if (eol) y <= eof ? '0 : y + 1'b1;
         end
         if (early) begin
            frame_err <= 1'b1;
            st <= PAD_FRAME;
         end else if (emit && eof) begin
            frame_err <= st == PASS && !s_axis_tlast;
            st <= WAIT_SOF;
         end else if (emit && (st == PASS || st == WAIT_SOF)) begin
            frame_err <= eol != s_axis_tlast;
            st <= eol && !s_axis_tlast ? DRAIN : !eol && s_axis_tlast ? PAD_LINE : PASS;
         end else if (emit && st == PAD_LINE && eol)
            st <= PASS;
         else if (accept && st == DRAIN && s_axis_tlast)
            st <= PASS;
      end
`ifdef FRAME_SANITIZER_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_count <= '0;
      else if (frame_err && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
`endif
endmodule

// File: tb/tb_axis_frame_sanitizer.sv
// tb_axis_frame_sanitizer: table-driven frame scenarios for axis_frame_sanitizer at WIDTH=4, HEIGHT=2.
module tb_axis_frame_sanitizer;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [23:0] s_axis_tdata = '0, m_axis_tdata;
   logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0, s_axis_tready;
   logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready = 1'b1, frame_err;
`ifdef FRAME_SANITIZER_STATS_EN
   logic [15:0] err_count;
`endif
   always #5 clk = ~clk;

   axis_frame_sanitizer #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(24), .PAD_VALUE(24'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready), .frame_err(frame_err)
`ifdef FRAME_SANITIZER_STATS_EN
      , .err_count(err_count)
`endif
   );

   typedef struct {
      int n_in;
      logic [25:0] in_b[24];
      int n_out;
      logic [25:0] out_b[24];
      int errs;
      int stalls;
      bit toggle;
   } scen_t;
   scen_t sc[7];
   int checks = 0, errors = 0, nerr = 0;
   logic [25:0] got[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void ai(int s, logic [23:0] d, bit l, bit u);
      sc[s].in_b[sc[s].n_in] = {u, l, d};
      sc[s].n_in++;
   endfunction

   function automatic void ao(int s, logic [23:0] d, bit l, bit u);
      sc[s].out_b[sc[s].n_out] = {u, l, d};
      sc[s].n_out++;
   endfunction

   // beats base+from..base+to of a clean frame, passed through unchanged
   function automatic void fio(int s, logic [23:0] base, int from, int to);
      for (int k = from; k <= to; k++) begin
         ai(s, base + 24'(k), k % 4 == 3, k == 0);
         ao(s, base + 24'(k), k % 4 == 3, k == 0);
      end
   endfunction

   // output monitor: collects handshaken beats, counts frame_err, checks stall stability
   initial begin
      logic hold = 1'b0;
      logic [25:0] prev = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold) chk("stall_hold", {6'h0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                          {6'h0, 1'b1, prev});
            if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (frame_err) nerr++;
            hold = m_axis_tvalid && !m_axis_tready;
            prev = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         end else hold = 1'b0;
      end
   end

   task automatic run_scen(int s);
      int stalls = 0, guard;
      logic hs;
      got.delete();
      nerr = 0;
      for (int i = 0; i < sc[s].n_in; i++) begin
         {s_axis_tuser, s_axis_tlast, s_axis_tdata} = sc[s].in_b[i];
         s_axis_tvalid = 1'b1;
         guard = 0;
         forever begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (sc[s].toggle) m_axis_tready = !m_axis_tready;
            if (hs) break;
            stalls++;
            if (++guard > 50) begin
               chk($sformatf("s%0d_in_timeout", s), 32'(i), 32'(sc[s].n_in));
               break;
            end
         end
      end
      s_axis_tvalid = 1'b0;
      guard = 0;
      while (got.size() < sc[s].n_out && guard < 100) begin
         @(posedge clk);
         #1;
         if (sc[s].toggle) m_axis_tready = !m_axis_tready;
         guard++;
      end
      m_axis_tready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("s%0d_beat_count", s), 32'(got.size()), 32'(sc[s].n_out));
      for (int i = 0; i < sc[s].n_out && i < got.size(); i++)
         chk($sformatf("s%0d_beat%0d", s, i), 32'(got[i]), 32'(sc[s].out_b[i]));
      chk($sformatf("s%0d_frame_err", s), 32'(nerr), 32'(sc[s].errs));
      if (sc[s].stalls >= 0) chk($sformatf("s%0d_in_stalls", s), 32'(stalls), 32'(sc[s].stalls));
   endtask

   initial begin
      foreach (sc[i]) begin
         sc[i].n_in = 0;
         sc[i].n_out = 0;
         sc[i].toggle = 1'b0;
      end
      fio(0, 24'hA0, 0, 7);
      sc[0].errs = 0; sc[0].stalls = 0;
      ai(1, 24'hA0, 0, 1); ai(1, 24'hA1, 1, 0);
      ao(1, 24'hA0, 0, 1); ao(1, 24'hA1, 0, 0); ao(1, 0, 0, 0); ao(1, 0, 1, 0);
      fio(1, 24'hA0, 4, 7);
      sc[1].errs = 1; sc[1].stalls = 2;
      ai(2, 24'hA0, 0, 1); ai(2, 24'hA1, 0, 0); ai(2, 24'hA2, 0, 0);
      ai(2, 24'hA3, 0, 0); ai(2, 24'hA4, 0, 0); ai(2, 24'hA5, 1, 0);
      ao(2, 24'hA0, 0, 1); ao(2, 24'hA1, 0, 0); ao(2, 24'hA2, 0, 0); ao(2, 24'hA3, 1, 0);
      fio(2, 24'hB0, 4, 7);
      sc[2].errs = 1; sc[2].stalls = 0;
      fio(3, 24'hA0, 0, 4);
      ao(3, 0, 0, 0); ao(3, 0, 0, 0); ao(3, 0, 1, 0);
      fio(3, 24'hB0, 0, 7);
      sc[3].errs = 1; sc[3].stalls = 4;
      fio(4, 24'hC0, 0, 7);
      sc[4].errs = 0; sc[4].stalls = -1; sc[4].toggle = 1'b1;
      ai(5, 24'h11, 0, 0); ai(5, 24'h22, 1, 0);
      fio(5, 24'hD0, 0, 7);
      sc[5].errs = 0; sc[5].stalls = 0;
      ai(6, 24'hE0, 1, 1);
      ao(6, 24'hE0, 0, 1); ao(6, 0, 0, 0); ao(6, 0, 0, 0); ao(6, 0, 1, 0);
      fio(6, 24'hE0, 4, 7);
      sc[6].errs = 1; sc[6].stalls = 3;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_m_tdata", 32'(m_axis_tdata), 0);
      chk("rst_m_flags", {30'h0, m_axis_tlast, m_axis_tuser}, 0);
      chk("rst_s_tready", 32'(s_axis_tready), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("tready_before_edge", 32'(s_axis_tready), 0);
      @(posedge clk);
      #1;
      chk("tready_after_edge", 32'(s_axis_tready), 1);

      for (int s = 0; s < 4; s++) run_scen(s);
`ifdef FRAME_SANITIZER_STATS_EN
      chk("err_count_3", 32'(err_count), 3);
`endif
      for (int s = 4; s < 7; s++) run_scen(s);

      // abandon a frame two beats in with an asynchronous reset
      {s_axis_tuser, s_axis_tlast, s_axis_tdata} = {1'b1, 1'b0, 24'hF0};
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
      {s_axis_tuser, s_axis_tdata} = {1'b0, 24'hF1};
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_m_tvalid", 32'(m_axis_tvalid), 0);
      chk("midrst_s_tready", 32'(s_axis_tready), 0);
`ifdef FRAME_SANITIZER_STATS_EN
      chk("midrst_err_count", 32'(err_count), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_scen(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_frame_sanitizer.md
AXIS_FRAME_SANITIZER -- requirements
Module: axis_frame_sanitizer

Upstream stage of the barrel-correction pipeline. It turns an arbitrary camera AXI4-Stream into exactly WIDTH x HEIGHT beats per frame: tuser marks start of frame (SOF), tlast marks end of line (EOL).

Interface
REQ-001 Parameter WIDTH, default 1920, pixels per line (>=2).
REQ-002 Parameter HEIGHT, default 1080, lines per frame (>=1).
REQ-003 Parameter DATA_WIDTH, default 24, pixel width in bits.
REQ-004 Parameter PAD_VALUE, default 0, DATA_WIDTH-bit value emitted for padded pixels.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 s_axis_tdata/tvalid/tlast/tuser  in  DATA_WIDTH/1/1/1  raw input stream; tlast=EOL, tuser=SOF.
REQ-008 s_axis_tready  out  1  input accept.
REQ-009 m_axis_tdata/tvalid/tlast/tuser  out  DATA_WIDTH/1/1/1  sanitized stream.
REQ-010 m_axis_tready  in  1  downstream accept.
REQ-011 frame_err  out  1  one-cycle pulse per detected error event.

Function
REQ-012 States: WAIT_SOF, PASS, PAD_LINE, PAD_FRAME, DRAIN; counters x (0..WIDTH-1) and y (0..HEIGHT-1).
REQ-013 Output register: single stage, loaded when !m_axis_tvalid || m_axis_tready; latency input-accept to m_axis_tvalid = 1 cycle; sustains 1 beat/clk.
REQ-014 Stall rule: m_axis_* shall hold stable while m_axis_tvalid && !m_axis_tready.
REQ-015 Ready rule: s_axis_tready = output-register-free AND state in {WAIT_SOF, PASS, DRAIN}; it shall be 0 in PAD_LINE and PAD_FRAME.
REQ-016 WAIT_SOF: accept and discard beats with tuser=0.
REQ-017 WAIT_SOF, beat with tuser=1: emit it as pixel (0,0) with m_axis_tuser=1, then go to PASS.
REQ-018 m_axis_tuser shall be 1 only at x=0,y=0; m_axis_tlast shall be 1 exactly when x=WIDTH-1, whatever the input tlast.
REQ-019 PASS, input tlast at x<WIDTH-1 (short line): emit that pixel, pulse frame_err, enter PAD_LINE.
REQ-020 PAD_LINE: emit PAD_VALUE through x=WIDTH-1, then return to PASS.
REQ-021 PASS, x=WIDTH-1 with input tlast=0 (long line): emit pixel with m_axis_tlast=1, pulse frame_err, enter DRAIN.
REQ-022 DRAIN: discard beats up to and including the next input tlast, then return to PASS.
REQ-023 DRAIN, tuser beat arrives: treat as early SOF (REQ-024) and do not consume the beat.
REQ-024 PASS, tuser=1 at (x,y)!=(0,0) (early SOF): do not accept the beat, pulse frame_err, enter PAD_FRAME.
REQ-025 PAD_FRAME: emit PAD_VALUE through x=WIDTH-1, y=HEIGHT-1, then go to WAIT_SOF; the held beat becomes the next frame's SOF.
REQ-026 When the beat at x=WIDTH-1, y=HEIGHT-1 is emitted in any state, go to WAIT_SOF.
REQ-027 Input tlast and tuser on the same beat at (0,0): SOF takes effect, the pixel is emitted, then the short-line rule applies.
REQ-028 WIDTH=1 is unsupported; x and y wrap only through REQ-020, REQ-025 and REQ-026.

Reset
REQ-029 On rst_n low: state=WAIT_SOF, x=y=0; m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, s_axis_tready=0, frame_err=0.
REQ-030 s_axis_tready may rise only from the first clk edge after rst_n deasserts.
REQ-031 Reset mid-frame abandons the partial frame without padding it.

Configuration
REQ-032 Macro FRAME_SANITIZER_STATS_EN defined: add output err_count [15:0], which increments on every frame_err pulse, saturates at 16'hFFFF and resets to 0.
REQ-033 Macro undefined: no err_count port or logic; all other behaviour is identical.

Verification (WIDTH=4, HEIGHT=2, PAD_VALUE=0)
REQ-034 Clean frame A0..A7, SOF on A0, tlast on A3/A7 -> A0..A7 out, tuser on A0, tlast on A3/A7, frame_err never asserted.
REQ-035 Line 0 = A0,A1 with tlast on A1 -> out A0,A1,0,0 (tlast on 4th beat); one frame_err pulse; s_axis_tready=0 for 2 beats.
REQ-036 Line 0 = A0..A5 with tlast on A5 -> out A0..A3 with tlast on A3; A4,A5 dropped; one frame_err pulse; line 1 unaffected.
REQ-037 SOF on B0 after A0..A4 -> out A0..A4,0,0,0, then B0 with tuser=1; one frame_err pulse.
REQ-038 m_axis_tready toggled 1010... during clean frame -> output data and order identical to REQ-034, no beat lost or duplicated.
REQ-039 With FRAME_SANITIZER_STATS_EN: REQ-035..REQ-037 run back-to-back -> err_count=3; rst_n pulse mid-frame -> err_count=0, m_axis_tvalid=0, next SOF accepted cleanly.
